// File: rtl/tcam_pkg.sv
// tcam_pkg: shared TCAM lookup defaults, derived widths and search FSM encoding
package tcam_pkg;
  localparam int DEF_DATA_BITS  = 10;
  localparam int DEF_FRAGMENTS  = 5;
  localparam int DEF_FRAG_BITS  = 3;
  localparam int DEF_MATCH_WID  = 4;
  localparam int DEF_IDX_WID    = 2;
  localparam int DEF_EARLY_EXIT = 1;
  localparam int DEF_FRAG_WID   = DEF_DATA_BITS / DEF_FRAGMENTS;
  localparam int DEF_ADDR_WID   = DEF_FRAG_BITS + DEF_FRAG_WID;
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SHIFT = 3'd2,
    S_CAPT  = 3'd3,
    S_REQ   = 3'd4,
    S_RESP  = 3'd5,
    S_DONE  = 3'd6
  } state_t;
  function automatic int addr_wid(input int data_bits, input int fragments, input int frag_bits);
    return frag_bits + data_bits / fragments;
  endfunction
endpackage

// File: rtl/tcam_prio_enc.sv
// tcam_prio_enc: lowest-set-bit index and hit flag of a match vector
module tcam_prio_enc #(
  parameter int MATCH_WID = 4,
  parameter int IDX_WID   = 2
)(
  input  logic [MATCH_WID-1:0] vec,
  output logic                 hit,
  output logic [IDX_WID-1:0]   idx
);
  always_comb begin
    hit = |vec;
    idx = '0;
    for (int i = MATCH_WID - 1; i >= 0; i--)
      if (vec[i]) idx = IDX_WID'(i);
  end
endmodule

// File: rtl/tcam_search_ctrl.sv
// tcam_search_ctrl: sequences fragment reads for one key and AND-accumulates the match vectors
module tcam_search_ctrl
  import tcam_pkg::*;
#(
  parameter int DATA_BITS  = DEF_DATA_BITS,
  parameter int FRAGMENTS  = DEF_FRAGMENTS,
  parameter int FRAG_BITS  = DEF_FRAG_BITS,
  parameter int MATCH_WID  = DEF_MATCH_WID,
  parameter int IDX_WID    = DEF_IDX_WID,
  parameter int EARLY_EXIT = DEF_EARLY_EXIT,
  localparam int ADDR_WID  = addr_wid(DATA_BITS, FRAGMENTS, FRAG_BITS)
)(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_key_valid,
  input  logic [DATA_BITS-1:0] i_key,
  output logic                 o_key_ready,
  output logic [DATA_BITS-1:0] o_frag_key,
  output logic                 o_frag_load,
  output logic                 o_frag_shift,
  input  logic [ADDR_WID-1:0]  i_frag_addr,
  output logic                 o_mem_req,
  output logic [ADDR_WID-1:0]  o_mem_addr,
  input  logic                 i_mem_ack,
  input  logic                 i_mem_rvalid,
  input  logic [MATCH_WID-1:0] i_mem_rdata,
  output logic                 o_result_valid,
  output logic [MATCH_WID-1:0] o_match_vec,
  output logic                 o_hit,
  output logic [IDX_WID-1:0]   o_hit_idx,
  input  logic                 i_result_ready
);
  state_t state, nxt;
  logic [MATCH_WID-1:0] acc, nacc;
  logic [FRAG_BITS-1:0] cnt;
  logic hit_c, last;
  logic [IDX_WID-1:0] idx_c;
  assign nacc = acc & i_mem_rdata;
  assign last = (cnt == FRAG_BITS'(FRAGMENTS - 1)) || (EARLY_EXIT != 0 && nacc == '0);
  assign o_key_ready    = state == S_IDLE;
  assign o_frag_load    = state == S_LOAD;
  assign o_frag_shift   = state == S_SHIFT;
  assign o_mem_req      = state == S_REQ;
  assign o_result_valid = state == S_DONE;
  tcam_prio_enc #(.MATCH_WID(MATCH_WID), .IDX_WID(IDX_WID)) u_enc (
    .vec(nacc),
    .hit(hit_c),
    .idx(idx_c)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= S_IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  nxt = i_key_valid ? S_LOAD : S_IDLE;
      S_LOAD:  nxt = S_SHIFT;
      S_SHIFT: nxt = S_CAPT;
      S_CAPT:  nxt = S_REQ;
      S_REQ:   nxt = i_mem_ack ? S_RESP : S_REQ;
      S_RESP:  nxt = !i_mem_rvalid ? S_RESP : last ? S_DONE : S_SHIFT;
      S_DONE:  nxt = i_result_ready ? S_IDLE : S_DONE;
      default: nxt = S_IDLE;
    endcase
  end
  // the result is latched on DONE entry so it stays stable while the consumer stalls
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      acc         <= '1;
      cnt         <= '0;
      o_frag_key  <= '0;
      o_mem_addr  <= '0;
      o_match_vec <= '0;
      o_hit       <= 1'b0;
      o_hit_idx   <= '0;
    end else begin
      if (state == S_IDLE && i_key_valid) begin
        o_frag_key <= i_key;
        acc        <= '1;
        cnt        <= '0;
      end
      if (state == S_CAPT) o_mem_addr <= i_frag_addr;
      if (state == S_RESP && i_mem_rvalid) begin
        acc <= nacc;
        if (last) begin
          o_match_vec <= nacc;
          o_hit       <= hit_c;
          o_hit_idx   <= idx_c;
        end else cnt <= cnt + FRAG_BITS'(1);
      end
    end
endmodule

// File: doc/tcam_search_ctrl.md
Name: tcam_search_ctrl

Overview:
Search sequencer for the SDRAM-based TCAM lookup path. It accepts a search key on a valid/ready handshake and drives the fragmentation unit (load, then one shift per fragment). It issues one SDRAM read per fragment address, AND-accumulates the returned match vectors and returns the final match vector, a hit flag and the lowest matching rule index. It sits between the key ingress and the fragmentation unit / SDRAM read port.

Parameters:
DATA_BITS, 10, key length
FRAGMENTS, 5, number of fragments per key
FRAG_BITS, 3, prefix bits encoding the fragment number
MATCH_WID, 4, rules per SDRAM word (match vector width)
IDX_WID, 2, width of the matching rule index (clog2 MATCH_WID)
EARLY_EXIT, 1, when 1, stop the search as soon as the accumulated vector is all-zero
Localparams: FRAG_WID = DATA_BITS/FRAGMENTS; ADDR_WID = FRAG_BITS+FRAG_WID.

Ports:
clk  in  1  clock; all logic on the rising edge
reset  in  1  asynchronous reset, active-high
i_key_valid  in  1  search key valid
i_key  in  DATA_BITS  search key
o_key_ready  out  1  controller idle; a key is accepted when i_key_valid and o_key_ready are both high
o_frag_key  out  DATA_BITS  registered key, drives the fragmentation unit's key input
o_frag_load  out  1  load strobe to the fragmentation unit
o_frag_shift  out  1  shift strobe to the fragmentation unit
i_frag_addr  in  ADDR_WID  fragment address {prefix, fragment} from the fragmentation unit
o_mem_req  out  1  SDRAM read request
o_mem_addr  out  ADDR_WID  SDRAM read address
i_mem_ack  in  1  request accepted
i_mem_rvalid  in  1  read data valid
i_mem_rdata  in  MATCH_WID  match vector read at o_mem_addr
o_result_valid  out  1  result available
o_match_vec  out  MATCH_WID  final AND-accumulated vector
o_hit  out  1  OR-reduction of o_match_vec
o_hit_idx  out  IDX_WID  lowest set bit index of o_match_vec; 0 when there is no hit
i_result_ready  in  1  result consumed

Behaviour:
- FSM states: IDLE, LOAD, SHIFT, CAPT, REQ, RESP, DONE. State decoding produces Moore outputs:
  - o_key_ready = IDLE
  - o_frag_load = LOAD
  - o_frag_shift = SHIFT
  - o_mem_req = REQ
  - o_result_valid = DONE
- IDLE: on handshake, register the key into o_frag_key, set acc = all-ones and cnt = 0, then go to LOAD.
- LOAD goes to SHIFT.
- SHIFT goes to CAPT. The fragment address becomes valid one cycle after the shift.
- CAPT: register i_frag_addr into o_mem_addr, then go to REQ.
- REQ: hold o_mem_req high with o_mem_addr stable until i_mem_ack, then go to RESP.
- RESP: wait for i_mem_rvalid, then set acc &= i_mem_rdata.
  - If cnt == FRAGMENTS-1, or EARLY_EXIT and (acc & rdata) == 0, go to DONE.
  - Otherwise cnt++ and go to SHIFT.
- DONE: o_match_vec = acc, o_hit and o_hit_idx are registered on entry and held until i_result_ready; then go to IDLE. o_result_valid drops in the cycle after the accepting edge.
- i_mem_rvalid outside RESP is ignored. rvalid must come at least one cycle after ack; rvalid in the ack cycle is not captured.
- i_key_valid outside IDLE is ignored; the key is not buffered.
- Latency with ack in the request cycle and rvalid one cycle later: 4 cycles per fragment. The handshake is in cycle 0 and o_result_valid rises in cycle 2+4*FRAGMENTS (22 at defaults).
- cnt width is FRAG_BITS; no wrap occurs because cnt never exceeds FRAGMENTS-1.
- An early exit leaves the fragmentation unit mid-key. This is harmless because the next LOAD reinitialises it.
- Reset (any state) immediately returns the FSM to IDLE.
  - o_key_ready = 1; all other outputs = 0; acc = all-ones; cnt = 0.
  - Any in-flight SDRAM response after reset is ignored.

Decomposition:
- Package tcam_pkg holds:
  - state encoding (3-bit localparams)
  - FRAG_WID/ADDR_WID derivation
  - the shared default parameter values, also used by the fragmentation unit
- One sub-module: tcam_prio_enc (MATCH_WID to IDX_WID lowest-set-bit encoder plus hit flag), reused by later result/priority blocks.

Test Plan:
- Defaults, key 10'b1110010011, memory model ack same cycle, rvalid next cycle, data 1111/1110/0110/0111/1110 -> addresses 0x03, 0x04, 0x09, 0x0E, 0x13 in order; o_match_vec=0110, o_hit=1, o_hit_idx=1; o_result_valid at cycle 22.
- Same key, second read returns 0000, EARLY_EXIT=1 -> only 0x03, 0x04 requested; o_match_vec=0000, o_hit=0, o_hit_idx=0.
- Ack delayed 3 cycles per request -> o_mem_req/o_mem_addr held stable during the wait; same result as the first test, latency +15.
- i_result_ready held low 5 cycles, i_key_valid high with a new key -> result held stable, o_key_ready=0; new key accepted in the cycle after ready.
- Reset asserted while in REQ for key 1, then key 2 -> o_mem_req drops asynchronously; key 2 searched from fragment 0 with acc all-ones; a stray rvalid in IDLE has no effect.
- Back-to-back keys with i_result_ready=1 -> one idle cycle between DONE and the next acceptance; no acc/cnt carry-over.
